r4_butterfly_stream: RTL
========================

R4_BUTTERFLY_STREAM -- requirements
Module: r4_butterfly_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning signed input width of each real/imag component (DATA_W >= 4).
REQ-002 SHALL have parameter OUT_W, fixed at DATA_W+2, meaning signed output component width (full precision, no overflow possible).
REQ-003 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  input sample beat offered.
REQ-006 in_ready  output  1  block accepts an input beat this cycle.
REQ-007 in_re  input  DATA_W  signed real part of sample x[k].
REQ-008 in_im  input  DATA_W  signed imaginary part of sample x[k].
REQ-009 inverse  input  1  0 = forward DFT, 1 = inverse DFT; sampled on the first beat of a frame.
REQ-010 out_valid  output  1  output result beat offered.
REQ-011 out_ready  input  1  consumer accepts an output beat.
REQ-012 out_re  output  OUT_W  signed real part of X[out_idx].
REQ-013 out_im  output  OUT_W  signed imaginary part of X[out_idx].
REQ-014 out_idx  output  2  index of the current result beat, 0..3.
REQ-015 busy  output  1  high whenever state is not LOAD or a partial frame is held.

Function
REQ-016 A beat transfers when valid and ready are both high on a rising edge; no other condition transfers data.
REQ-017 FSM states SHALL be LOAD, CALC, DRAIN; LOAD -> CALC on the 4th input transfer; CALC -> DRAIN unconditionally after one cycle; DRAIN -> LOAD on transfer of out_idx 3.
REQ-018 in_ready SHALL be high only in LOAD; out_valid SHALL be high only in DRAIN.
REQ-019 In LOAD, transfer n (n = 0..3, 2-bit counter) SHALL store the sample as x[n]; the counter wraps to 0 on the 4th transfer.
REQ-020 In CALC, results SHALL be registered: X0 = x0+x1+x2+x3; X2 = x0-x1+x2-x3; forward X1 = x0-j*x1-x2+j*x3, X3 = x0+j*x1-x2-j*x3; inverse swaps X1 and X3.
REQ-021 All arithmetic SHALL sign-extend inputs to OUT_W before summing; no scaling, rounding or saturation.
REQ-022 Latency: if the 4th input transfers at edge N, out_valid SHALL be high in the cycle after edge N+1, with out_idx = 0.
REQ-023 In DRAIN, out_idx SHALL advance 0,1,2,3 on each output transfer; with out_ready low, out_re/out_im/out_idx SHALL hold stable.
REQ-024 in_valid asserted outside LOAD SHALL be ignored; gaps in in_valid during LOAD SHALL keep the partial frame.
REQ-025 The inverse value sampled on beat 0 SHALL apply to the whole frame; changes on beats 1..3 are ignored.
REQ-026 Back-to-back frames: in_ready SHALL be high the cycle after the out_idx-3 transfer.

Reset
REQ-027 RST high at an edge SHALL force state LOAD, input counter 0, out_idx 0, out_valid 0, busy 0, in_ready 1 (after release), out_re/out_im 0, stored samples 0.
REQ-028 RST mid-frame (LOAD, CALC or DRAIN) SHALL discard all partial input and undelivered results; no result beat of that frame appears afterwards.

Structure
REQ-029 State enum (LOAD, CALC, DRAIN) and a width helper for OUT_W SHALL live in shared package r4_pkg.
REQ-030 The combinational butterfly arithmetic SHALL be one sub-module, r4_bfly_core, parametrised by DATA_W and taking the inverse flag; the FSM, sample buffer and output register stay in r4_butterfly_stream.

Verification (DATA_W = 8)
REQ-031 Impulse: x = (1,0),(0,0),(0,0),(0,0), forward -> four beats all (1,0), out_idx 0..3.
REQ-032 Ramp: real 1,2,3,4, imag 0, forward -> X0=(10,0), X1=(-2,2), X2=(-2,0), X3=(-2,-2); same with inverse=1 -> X1=(-2,-2), X3=(-2,2).
REQ-033 Extreme: all four inputs (-128,-128) -> X0=(-512,-512), X1..X3=(0,0); no wrap in 10-bit outputs.
REQ-034 Backpressure: hold out_ready low 5 cycles during DRAIN at out_idx 1 -> outputs stable, in_ready stays 0; on release delivery continues at idx 1, then in_ready rises the cycle after idx 3 transfers.
REQ-035 Reset mid-DRAIN after idx 1 transfers -> out_valid 0 next cycle, in_ready 1, new impulse frame yields exactly four (1,0) beats.
REQ-036 Gapped input with inverse toggled on beats 1..3 -> results match the mode sampled on beat 0; latency per REQ-022 from 4th transfer.

Source files
------------

// File: rtl/r4_pkg.sv
// Shared types and width helpers for the streaming radix-4 butterfly.
package r4_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Sum of four sign-extended operands needs two extra bits.
  function automatic int out_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/r4_butterfly_stream_if.sv
// Input sample stream and output result stream of r4_butterfly_stream.
interface r4_butterfly_stream_if #(
  parameter int DATA_W = 8
);
  import r4_pkg::*;
  localparam int OUT_W = out_w(DATA_W);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     inverse;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_re;
  logic signed [OUT_W-1:0]  out_im;
  logic [1:0]               out_idx;
  logic                     busy;

  modport master (
    output in_valid, in_re, in_im, inverse, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, inverse, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, busy
  );

endinterface

// File: rtl/r4_bfly_core.sv
// Combinational 4-point DFT butterfly, full precision, forward or inverse.
module r4_bfly_core
  import r4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = out_w(DATA_W)
) (
  input  logic signed [DATA_W-1:0] x_re [4],
  input  logic signed [DATA_W-1:0] x_im [4],
  input  logic                     inverse,
  output logic signed [OUT_W-1:0]  y_re [4],
  output logic signed [OUT_W-1:0]  y_im [4]
);

  logic signed [OUT_W-1:0] a_re [4];
  logic signed [OUT_W-1:0] a_im [4];
  logic signed [OUT_W-1:0] f1_re, f1_im, f3_re, f3_im;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_re[i] = {{(OUT_W-DATA_W){x_re[i][DATA_W-1]}}, x_re[i]};
      a_im[i] = {{(OUT_W-DATA_W){x_im[i][DATA_W-1]}}, x_im[i]};
    end
  end

  // -j*(a+jb) = b - ja and +j*(a+jb) = -b + ja, so the rotations are re/im swaps.
  assign f1_re = a_re[0] + a_im[1] - a_re[2] - a_im[3];
  assign f1_im = a_im[0] - a_re[1] - a_im[2] + a_re[3];
  assign f3_re = a_re[0] - a_im[1] - a_re[2] + a_im[3];
  assign f3_im = a_im[0] + a_re[1] - a_im[2] - a_re[3];

  assign y_re[0] = a_re[0] + a_re[1] + a_re[2] + a_re[3];
  assign y_im[0] = a_im[0] + a_im[1] + a_im[2] + a_im[3];
  assign y_re[2] = a_re[0] - a_re[1] + a_re[2] - a_re[3];
  assign y_im[2] = a_im[0] - a_im[1] + a_im[2] - a_im[3];
  assign y_re[1] = inverse ? f3_re : f1_re;
  assign y_im[1] = inverse ? f3_im : f1_im;
  assign y_re[3] = inverse ? f1_re : f3_re;
  assign y_im[3] = inverse ? f1_im : f3_im;

endmodule

// File: rtl/r4_butterfly_stream.sv
// Streaming 4-point DFT: collects four samples, computes once, drains four results.
module r4_butterfly_stream
  import r4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = out_w(DATA_W)
) (
  input  logic                  CLK,
  input  logic                  RST,
  r4_butterfly_stream_if.slave  bus
);

  state_t state, state_nxt;

  logic [1:0]               cnt_p0;
  logic                     inv_p0;
  logic signed [DATA_W-1:0] x_re_p0 [4];
  logic signed [DATA_W-1:0] x_im_p0 [4];

  logic signed [OUT_W-1:0]  y_re [4];
  logic signed [OUT_W-1:0]  y_im [4];

  logic signed [OUT_W-1:0]  res_re_p1 [4];
  logic signed [OUT_W-1:0]  res_im_p1 [4];
  logic [1:0]               idx_p1;

  logic in_xfer, out_xfer;

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_xfer && cnt_p0 == 2'd3)  state_nxt = CALC;
      CALC:    state_nxt = DRAIN;
      DRAIN:   if (out_xfer && idx_p1 == 2'd3) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == DRAIN);
    bus.busy      = (state != LOAD) || (cnt_p0 != 2'd0);
  end

  // Stage 0: sample buffer; the mode is latched only with the first beat of a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0 <= 2'd0;
      inv_p0 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_re_p0[i] <= '0;
        x_im_p0[i] <= '0;
      end
    end else if (in_xfer) begin
      x_re_p0[cnt_p0] <= bus.in_re;
      x_im_p0[cnt_p0] <= bus.in_im;
      cnt_p0          <= cnt_p0 + 2'd1;
      if (cnt_p0 == 2'd0) inv_p0 <= bus.inverse;
    end
  end

  r4_bfly_core #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_core (
    .x_re    (x_re_p0),
    .x_im    (x_im_p0),
    .inverse (inv_p0),
    .y_re    (y_re),
    .y_im    (y_im)
  );

  // Stage 1: result register, captured in CALC and walked out in DRAIN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_p1 <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        res_re_p1[i] <= '0;
        res_im_p1[i] <= '0;
      end
    end else if (state == CALC) begin
      idx_p1    <= 2'd0;
      res_re_p1 <= y_re;
      res_im_p1 <= y_im;
    end else if (out_xfer) begin
      idx_p1 <= idx_p1 + 2'd1;
    end
  end

  assign bus.out_re  = res_re_p1[idx_p1];
  assign bus.out_im  = res_im_p1[idx_p1];
  assign bus.out_idx = idx_p1;

endmodule
